// File: rtl/gelato_warp_scheduler_if.sv
// Issue bus between the warp scheduler and the execute stage.
// Ports: issue_valid/issue_ready handshake plus issue_warp/rd/rs1/rs2 payload.
interface gelato_warp_scheduler_if #(
    parameter int WARP_NUM = 4,
    parameter int REG_W    = 5
);
    localparam int WW = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1;

    logic             issue_valid;
    logic             issue_ready;
    logic [WW-1:0]    issue_warp;
    logic [REG_W-1:0] issue_rd;
    logic [REG_W-1:0] issue_rs1;
    logic [REG_W-1:0] issue_rs2;

    modport master (
        output issue_valid, issue_warp, issue_rd, issue_rs1, issue_rs2,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_warp, issue_rd, issue_rs1, issue_rs2,
        output issue_ready
    );
endinterface

// File: rtl/gelato_warp_scheduler.sv
// Warp scheduler: scoreboard hazard check, round-robin pick, 1-deep issue register.
// Ports: clk, rst_n (sync, active-low), rdy (global enable), inst_valid/inst_rd/
//   inst_rs1/inst_rs2 (per-warp decoded instr), inst_ready (one-hot pop),
//   sb_regs (dirty-register table), sb_warp_num/sb_new_reg (record request),
//   iss (issue bus, master side).
// Macro GELATO_SCHED_GTO_EN: greedy-then-oldest, search starts at last_picked.
module gelato_warp_scheduler #(
    parameter int WARP_NUM = 4,
    parameter int SB_SIZE  = 4,
    parameter int REG_W    = 5,
    localparam int WW      = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rdy,
    input  logic [WARP_NUM-1:0]               inst_valid,
    input  logic [WARP_NUM*REG_W-1:0]         inst_rd,
    input  logic [WARP_NUM*REG_W-1:0]         inst_rs1,
    input  logic [WARP_NUM*REG_W-1:0]         inst_rs2,
    output logic [WARP_NUM-1:0]               inst_ready,
    input  logic [WARP_NUM*SB_SIZE*REG_W-1:0] sb_regs,
    output logic [WW-1:0]                     sb_warp_num,
    output logic [REG_W-1:0]                  sb_new_reg,
    gelato_warp_scheduler_if.master           iss
);

    logic [WARP_NUM-1:0] haz;
    logic [WARP_NUM-1:0] free;
    logic [WARP_NUM-1:0] elig;

    logic             valid_q, valid_d;
    logic [WW-1:0]    warp_q, warp_d;
    logic [REG_W-1:0] rd_q, rd_d;
    logic [REG_W-1:0] rs1_q, rs1_d;
    logic [REG_W-1:0] rs2_q, rs2_d;
    logic [WW-1:0]    last_q, last_d;

    int            start;
    int            idx;
    logic          found;
    logic [WW-1:0] pick_w;
    logic          pick;

    // A nonzero slot matching any source/dest is a hazard; a zero slot is free.
    always_comb begin
        haz  = '0;
        free = '0;
        elig = '0;
        for (int w = 0; w < WARP_NUM; w++) begin
            for (int j = 0; j < SB_SIZE; j++) begin
                if (sb_regs[(w*SB_SIZE+j)*REG_W +: REG_W] == '0) begin
                    free[w] = 1'b1;
                end else if (sb_regs[(w*SB_SIZE+j)*REG_W +: REG_W] == inst_rs1[w*REG_W +: REG_W] ||
                             sb_regs[(w*SB_SIZE+j)*REG_W +: REG_W] == inst_rs2[w*REG_W +: REG_W] ||
                             sb_regs[(w*SB_SIZE+j)*REG_W +: REG_W] == inst_rd[w*REG_W +: REG_W]) begin
                    haz[w] = 1'b1;
                end
            end
            elig[w] = inst_valid[w] && !haz[w] &&
                      (inst_rd[w*REG_W +: REG_W] == '0 || free[w]);
        end
    end

    // Rotating priority search starting after (or, with GTO, at) the last pick.
    always_comb begin
`ifdef GELATO_SCHED_GTO_EN
        start = int'(last_q);
`else
        start = (int'(last_q) + 1) % WARP_NUM;
`endif
        idx    = 0;
        found  = 1'b0;
        pick_w = '0;
        for (int i = 0; i < WARP_NUM; i++) begin
            idx = (start + i) % WARP_NUM;
            if (!found && elig[idx]) begin
                found  = 1'b1;
                pick_w = WW'(idx);
            end
        end
        pick = rst_n && rdy && found && (!valid_q || iss.issue_ready);
    end

    // Next-state: rdy low freezes everything, including the issue register.
    always_comb begin
        valid_d = valid_q;
        warp_d  = warp_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        last_d  = last_q;
        if (rdy) begin
            if (pick) begin
                valid_d = 1'b1;
                warp_d  = pick_w;
                rd_d    = inst_rd[pick_w*REG_W +: REG_W];
                rs1_d   = inst_rs1[pick_w*REG_W +: REG_W];
                rs2_d   = inst_rs2[pick_w*REG_W +: REG_W];
                last_d  = pick_w;
            end else if (iss.issue_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            warp_q  <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            last_q  <= WW'(WARP_NUM - 1);
        end else begin
            valid_q <= valid_d;
            warp_q  <= warp_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        inst_ready  = '0;
        sb_warp_num = '0;
        sb_new_reg  = '0;
        if (pick) begin
            inst_ready[pick_w] = 1'b1;
            sb_warp_num        = pick_w;
            sb_new_reg         = inst_rd[pick_w*REG_W +: REG_W];
        end
    end

    assign iss.issue_valid = valid_q;
    assign iss.issue_warp  = warp_q;
    assign iss.issue_rd    = rd_q;
    assign iss.issue_rs1   = rs1_q;
    assign iss.issue_rs2   = rs2_q;

endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// Directed testbench for gelato_warp_scheduler.
// Drives per-warp instructions and scoreboard contents, checks picks and issue bus.
module tb_gelato_warp_scheduler;

    localparam int WN = 4;
    localparam int SB = 4;
    localparam int RW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rdy;
    logic [WN-1:0]     inst_valid;
    logic [WN*RW-1:0]  inst_rd, inst_rs1, inst_rs2;
    logic [WN-1:0]     inst_ready;
    logic [WN*SB*RW-1:0] sb_regs;
    logic [1:0]        sb_warp_num;
    logic [RW-1:0]     sb_new_reg;

    int n_checks = 0;
    int n_fail   = 0;

    gelato_warp_scheduler_if #(.WARP_NUM(WN), .REG_W(RW)) iss ();

    gelato_warp_scheduler #(.WARP_NUM(WN), .SB_SIZE(SB), .REG_W(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdy        (rdy),
        .inst_valid (inst_valid),
        .inst_rd    (inst_rd),
        .inst_rs1   (inst_rs1),
        .inst_rs2   (inst_rs2),
        .inst_ready (inst_ready),
        .sb_regs    (sb_regs),
        .sb_warp_num(sb_warp_num),
        .sb_new_reg (sb_new_reg),
        .iss        (iss.master)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change 1 after it, outputs are checked 2 after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_std();
        inst_valid = 4'hf;
        for (int w = 0; w < WN; w++) begin
            inst_rd[w*RW +: RW]  = RW'(w + 1);
            inst_rs1[w*RW +: RW] = '0;
            inst_rs2[w*RW +: RW] = '0;
        end
        sb_regs = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy = 1'b1;
        iss.issue_ready = 1'b1;
        set_std();
        tick();
        tick();
        #1;
        n_checks++;
        if (inst_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_inst_ready got %b want 0000", inst_ready);
        end
        n_checks++;
        if (sb_new_reg !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_sb_new_reg got %0d want 0", sb_new_reg);
        end
        n_checks++;
        if (iss.issue_valid !== 1'b0 || iss.issue_warp !== 2'd0 || iss.issue_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_issue got v=%b w=%0d rd=%0d want 0/0/0",
                     iss.issue_valid, iss.issue_warp, iss.issue_rd);
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (inst_ready !== 4'(1 << i) || sb_new_reg !== 5'(i + 1) || sb_warp_num !== 2'(i)) begin
                n_fail++;
                $display("FAIL rr_pick%0d got ready=%b rec=%0d w=%0d want %b/%0d/%0d",
                         i, inst_ready, sb_new_reg, sb_warp_num, 4'(1 << i), i + 1, i);
            end
            tick();
            #1;
            n_checks++;
            if (iss.issue_valid !== 1'b1 || iss.issue_warp !== 2'(i) || iss.issue_rd !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL rr_issue%0d got v=%b w=%0d rd=%0d want 1/%0d/%0d",
                         i, iss.issue_valid, iss.issue_warp, iss.issue_rd, i, i + 1);
            end
        end
    endtask

    task automatic test_hazard();
        int exp_w[6] = '{0, 2, 0, 2, 0, 1};
        set_std();
        inst_valid = 4'b0111;
        inst_rs1[1*RW +: RW] = 5'd7;
        sb_regs[(1*SB+0)*RW +: RW] = 5'd7;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) sb_regs[(1*SB+0)*RW +: RW] = 5'd0;
            #1;
            n_checks++;
            if (inst_ready !== 4'(1 << exp_w[i])) begin
                n_fail++;
                $display("FAIL hazard_pick%0d got %b want %b", i, inst_ready, 4'(1 << exp_w[i]));
            end
            tick();
        end
        #1;
        n_checks++;
        if (iss.issue_warp !== 2'd1 || iss.issue_rs1 !== 5'd7) begin
            n_fail++;
            $display("FAIL hazard_issue got w=%0d rs1=%0d want 1/7", iss.issue_warp, iss.issue_rs1);
        end
    endtask

    task automatic test_sb_full();
        set_std();
        inst_valid = 4'b0001;
        inst_rd[0 +: RW] = 5'd5;
        for (int j = 0; j < SB; j++) sb_regs[j*RW +: RW] = RW'(8 + j);
        #1;
        n_checks++;
        if (inst_ready !== 4'b0000 || sb_new_reg !== 5'd0) begin
            n_fail++;
            $display("FAIL full_block got ready=%b rec=%0d want 0000/0", inst_ready, sb_new_reg);
        end
        tick();
        #1;
        n_checks++;
        if (iss.issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain got v=%b want 0", iss.issue_valid);
        end
        inst_rd[0 +: RW] = 5'd0;
        inst_rs1[0 +: RW] = 5'd3;
        #1;
        n_checks++;
        if (inst_ready !== 4'b0001 || sb_new_reg !== 5'd0 || sb_warp_num !== 2'd0) begin
            n_fail++;
            $display("FAIL full_rd0_pick got ready=%b rec=%0d w=%0d want 0001/0/0",
                     inst_ready, sb_new_reg, sb_warp_num);
        end
        tick();
        #1;
        n_checks++;
        if (iss.issue_valid !== 1'b1 || iss.issue_rd !== 5'd0 || iss.issue_rs1 !== 5'd3) begin
            n_fail++;
            $display("FAIL full_rd0_issue got v=%b rd=%0d rs1=%0d want 1/0/3",
                     iss.issue_valid, iss.issue_rd, iss.issue_rs1);
        end
    endtask

    task automatic test_stall();
        set_std();
        iss.issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (inst_ready !== 4'b0000 || iss.issue_valid !== 1'b1 ||
                iss.issue_warp !== 2'd0 || iss.issue_rs1 !== 5'd3 || iss.issue_rd !== 5'd0) begin
                n_fail++;
                $display("FAIL stall%0d got ready=%b v=%b w=%0d rs1=%0d rd=%0d want 0000/1/0/3/0",
                         i, inst_ready, iss.issue_valid, iss.issue_warp, iss.issue_rs1, iss.issue_rd);
            end
            tick();
        end
        iss.issue_ready = 1'b1;
        #1;
        n_checks++;
        if (inst_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_release_pick got %b want 0010", inst_ready);
        end
        tick();
        #1;
        n_checks++;
        if (iss.issue_valid !== 1'b1 || iss.issue_warp !== 2'd1 || iss.issue_rd !== 5'd2) begin
            n_fail++;
            $display("FAIL stall_release_issue got v=%b w=%0d rd=%0d want 1/1/2",
                     iss.issue_valid, iss.issue_warp, iss.issue_rd);
        end
    endtask

    task automatic test_rdy();
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (inst_ready !== 4'b0000 || sb_new_reg !== 5'd0 ||
                iss.issue_valid !== 1'b1 || iss.issue_warp !== 2'd1) begin
                n_fail++;
                $display("FAIL rdy_low%0d got ready=%b rec=%0d v=%b w=%0d want 0000/0/1/1",
                         i, inst_ready, sb_new_reg, iss.issue_valid, iss.issue_warp);
            end
            tick();
        end
        rdy = 1'b1;
        #1;
        n_checks++;
        if (inst_ready !== 4'b0100 || sb_new_reg !== 5'd3) begin
            n_fail++;
            $display("FAIL rdy_resume got ready=%b rec=%0d want 0100/3", inst_ready, sb_new_reg);
        end
        tick();
        #1;
        n_checks++;
        if (iss.issue_warp !== 2'd2) begin
            n_fail++;
            $display("FAIL rdy_resume_issue got w=%0d want 2", iss.issue_warp);
        end
    endtask

    task automatic test_back_to_back();
`ifdef GELATO_SCHED_GTO_EN
        int exp_w[4] = '{0, 0, 0, 0};
`else
        int exp_w[4] = '{0, 2, 0, 2};
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_std();
        inst_valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (inst_ready !== 4'(1 << exp_w[i])) begin
                n_fail++;
                $display("FAIL b2b_pick%0d got %b want %b", i, inst_ready, 4'(1 << exp_w[i]));
            end
            tick();
            #1;
            n_checks++;
            if (iss.issue_valid !== 1'b1 || iss.issue_warp !== 2'(exp_w[i])) begin
                n_fail++;
                $display("FAIL b2b_issue%0d got v=%b w=%0d want 1/%0d",
                         i, iss.issue_valid, iss.issue_warp, exp_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        iss.issue_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (inst_ready !== 4'b0000 || sb_new_reg !== 5'd0) begin
            n_fail++;
            $display("FAIL midrst_comb got ready=%b rec=%0d want 0000/0", inst_ready, sb_new_reg);
        end
        tick();
        #1;
        n_checks++;
        if (iss.issue_valid !== 1'b0 || iss.issue_warp !== 2'd0 || iss.issue_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL midrst_issue got v=%b w=%0d rd=%0d want 0/0/0",
                     iss.issue_valid, iss.issue_warp, iss.issue_rd);
        end
        rst_n = 1'b1;
        iss.issue_ready = 1'b1;
        #1;
        n_checks++;
        if (inst_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_first_pick got %b want 0001", inst_ready);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hazard();
        test_sb_full();
        test_stall();
        test_rdy();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gelato_warp_scheduler.md
GELATO_WARP_SCHEDULER -- requirements
Module: gelato_warp_scheduler

Interface
REQ-001 SHALL have parameter WARP_NUM, default 4: number of warps arbitrated.
REQ-002 SHALL have parameter SB_SIZE, default 4: scoreboard slots per warp.
REQ-003 SHALL have parameter REG_W, default 5: register-number width; register 0 means "none".
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-007 SHALL have port inst_valid  input  WARP_NUM  per-warp decoded instruction present.
REQ-008 SHALL have port inst_rd / inst_rs1 / inst_rs2  input  WARP_NUM*REG_W each  per-warp register fields, warp w at bits [w*REG_W +: REG_W].
REQ-009 SHALL have port inst_ready  output  WARP_NUM  one-hot pop of the picked warp's instruction.
REQ-010 SHALL have port sb_regs  input  WARP_NUM*SB_SIZE*REG_W  scoreboard dirty-register table, slot j of warp w at index (w*SB_SIZE+j).
REQ-011 SHALL have port sb_warp_num / sb_new_reg  output  clog2(WARP_NUM) / REG_W  record request to the scoreboard.
REQ-012 SHALL have port issue_valid / issue_ready  output / input  1 / 1  issue handshake to the execute stage.
REQ-013 SHALL have port issue_warp / issue_rd / issue_rs1 / issue_rs2  output  clog2(WARP_NUM) / REG_W x3  issued instruction.

Function
REQ-014 Warp w SHALL be eligible iff inst_valid[w], no nonzero rs1/rs2/rd of w equals any slot of warp w in sb_regs (RAW/WAW), and, if rd!=0, at least one slot of warp w is 0.
REQ-015 A pick SHALL occur in a cycle iff rdy=1, at least one warp is eligible, and (issue_valid=0 or issue_ready=1).
REQ-016 On a pick of warp w: inst_ready[w]=1 that cycle (combinational), sb_warp_num=w, sb_new_reg=inst_rd[w], and the output register loads w/rd/rs1/rs2 with issue_valid=1 at the next edge (latency 1).
REQ-017 With no pick: inst_ready=0, sb_new_reg=0, sb_warp_num=0.
REQ-018 issue_valid=1 and issue_ready=0 SHALL hold all issue_* outputs stable.
REQ-019 issue_ready=1 with no pick SHALL clear issue_valid at the next edge; with a pick, the new instruction replaces the old back-to-back.
REQ-020 Round-robin: the search SHALL start at (last_picked+1) mod WARP_NUM, wrapping; last_picked updates only on a pick.
REQ-021 Hazard check SHALL use sb_regs directly with no bypass; the scoreboard updates on the pick edge, so the next cycle sees the new record.
REQ-022 rd=0 instructions SHALL issue regardless of scoreboard fullness and SHALL request no record (sb_new_reg=0).
REQ-023 rdy=0 SHALL suppress picks, hold last_picked and the output register, and force inst_ready=0, sb_new_reg=0.

Reset
REQ-024 When rst_n=0 at a clk edge: issue_valid=0, issue_warp/rd/rs1/rs2=0, last_picked=WARP_NUM-1 (warp 0 searched first).
REQ-025 While rst_n=0, inst_ready=0 and sb_new_reg=0, overriding rdy.
REQ-026 Reset mid-operation SHALL discard any held issue instruction without signalling.

Configuration
REQ-027 Macro GELATO_SCHED_GTO_EN SHALL select greedy-then-oldest: the search starts at last_picked itself, so an eligible last warp is re-picked.
REQ-028 Without GELATO_SCHED_GTO_EN, strict round-robin per REQ-020 SHALL apply.

Verification
REQ-029 After reset, warps 0-3 valid, rd=1..4, empty scoreboard, issue_ready=1 -> picks 0,1,2,3 on consecutive cycles; sb_new_reg 1,2,3,4.
REQ-030 Warp 1 sb_regs slot0=7, inst_rs1=7; warps 0,2 valid -> warp 1 never picked until slot cleared, then picked at its next round-robin turn.
REQ-031 Warp 0 all 4 slots nonzero (8..11): rd=5 -> blocked; rd=0, rs1=3 -> issued, sb_new_reg=0.
REQ-032 issue_ready=0 for 3 cycles with issue_valid=1 -> outputs stable, inst_ready=0; issue_ready=1 -> next instruction issued the following edge.
REQ-033 rdy=0 for 2 cycles with all warps eligible -> no inst_ready, last_picked unchanged; rdy=1 resumes at the expected warp.
REQ-034 GELATO_SCHED_GTO_EN defined, warps 0,2 eligible with hazard-free streams -> warp 0 picked every cycle; undefined -> 0,2,0,2.
